// File: rtl/crop_filter_mp.sv
`default_nettype none
// ============================================================================
// Module  : crop_filter_mp
// Crops a multi-pixel AXIS frame to a latched window; tracks max/min and framing errors.
// Revision: 1.0 - initial release
// ============================================================================
module crop_filter_mp #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int PIXELS_PER_BEAT = 4,
    parameter int IN_ROWS         = 8,
    parameter int IN_COLS         = 16,
    parameter int OUT_ROWS        = 4,
    parameter int OUT_COLS        = 8
) (
    input  logic                                       clk,
    input  logic                                       s_axis_resetn,
    input  logic                                       ap_start,
    output logic                                       ap_ready,
    output logic                                       ap_idle,
    output logic                                       ap_done,
    input  logic [$clog2(IN_COLS)-1:0]                 crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]                 crop_y0,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic [PIXELS_PER_BEAT*PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    input  logic                                       s_axis_tlast,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [PIXELS_PER_BEAT*PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
    output logic                                       m_axis_tuser,
    output logic                                       m_axis_tlast,
    output logic [PIXEL_BIT_WIDTH-1:0]                 max_value,
    output logic [PIXEL_BIT_WIDTH-1:0]                 min_value,
    output logic                                       frame_err
);

    localparam int c_dw    = PIXELS_PER_BEAT * PIXEL_BIT_WIDTH;
    localparam int c_cw    = $clog2(IN_COLS);
    localparam int c_rw    = $clog2(IN_ROWS);
    localparam int c_beats = IN_COLS / PIXELS_PER_BEAT;
    localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_x_max = IN_COLS - OUT_COLS;
    localparam int c_y_max = IN_ROWS - OUT_ROWS;
    localparam logic [c_cw-1:0] c_x_mask = ~c_cw'(PIXELS_PER_BEAT - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;
    logic [c_bw-1:0]            r_col;
    logic [c_rw-1:0]            r_row;
    logic [c_cw-1:0]            r_x0;
    logic [c_rw-1:0]            r_y0;
    logic [PIXEL_BIT_WIDTH-1:0] r_max;
    logic [PIXEL_BIT_WIDTH-1:0] r_min;
    logic                       r_err;

    logic [c_dw-1:0]            r_buf_data [2];
    logic                       r_buf_user [2];
    logic                       r_buf_last [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_count;

    logic                       w_start;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_in_win;
    logic                       w_first_win;
    logic                       w_last_win;
    logic                       w_final_beat;
    int                         w_row_i;
    int                         w_colpix;
    logic [c_cw-1:0]            w_x0_aligned;
    logic [c_cw-1:0]            w_x0_start;
    logic [c_rw-1:0]            w_y0_start;
    logic [PIXEL_BIT_WIDTH-1:0] w_beat_max;
    logic [PIXEL_BIT_WIDTH-1:0] w_beat_min;

    assign w_start  = (r_state == c_idle) && ap_start;
    assign w_accept = s_axis_tvalid && s_axis_tready;
    assign w_push   = w_accept && w_in_win;
    assign w_pop    = m_axis_tvalid && m_axis_tready;
    assign w_full   = (r_count == 2'd2);

    // Window position is evaluated on the counters of the beat currently offered.
    always_comb begin
        w_row_i      = int'(r_row);
        w_colpix     = int'(r_col) * PIXELS_PER_BEAT;
        w_in_win     = (w_row_i >= int'(r_y0)) && (w_row_i < int'(r_y0) + OUT_ROWS) &&
                       (w_colpix >= int'(r_x0)) && (w_colpix < int'(r_x0) + OUT_COLS);
        w_first_win  = (w_row_i == int'(r_y0)) && (w_colpix == int'(r_x0));
        w_last_win   = (w_row_i == int'(r_y0) + OUT_ROWS - 1) &&
                       (w_colpix == int'(r_x0) + OUT_COLS - PIXELS_PER_BEAT);
        w_final_beat = (r_row == c_rw'(IN_ROWS - 1)) && (r_col == c_bw'(c_beats - 1));
    end

    always_comb begin
        w_x0_aligned = crop_x0 & c_x_mask;
        w_x0_start   = (int'(w_x0_aligned) > c_x_max) ? c_cw'(c_x_max) : w_x0_aligned;
        w_y0_start   = (int'(crop_y0) > c_y_max) ? c_rw'(c_y_max) : crop_y0;
    end

    always_comb begin
        w_beat_max = r_max;
        w_beat_min = r_min;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            if (s_axis_tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] > w_beat_max)
                w_beat_max = s_axis_tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            if (s_axis_tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] < w_beat_min)
                w_beat_min = s_axis_tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!s_axis_resetn) r_state <= c_idle;
        else                r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (ap_start) w_next_state = c_run;
            c_run:   if (w_accept && w_final_beat) w_next_state = c_drain;
            c_drain: if (r_count == 2'd0) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        ap_idle       = (r_state == c_idle);
        ap_ready      = (r_state == c_idle);
        ap_done       = (r_state == c_drain) && (r_count == 2'd0);
        s_axis_tready = (r_state == c_run) && (!w_in_win || !w_full);
    end

    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            r_col <= '0;
            r_row <= '0;
            r_x0  <= '0;
            r_y0  <= '0;
            r_max <= '0;
            r_min <= '1;
            r_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_x0  <= w_x0_start;
                r_y0  <= w_y0_start;
                r_max <= '0;
                r_min <= '1;
                r_err <= 1'b0;
                r_col <= '0;
                r_row <= '0;
            end
            if (w_accept) begin
                if (r_col == c_bw'(c_beats - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == c_rw'(IN_ROWS - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                // The frame ends by count; tlast only flags disagreement.
                if (s_axis_tlast != w_final_beat) r_err <= 1'b1;
                if (w_in_win) begin
                    r_max <= w_beat_max;
                    r_min <= w_beat_min;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_user[i] <= 1'b0;
                r_buf_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= s_axis_tdata;
                r_buf_user[r_wr_ptr] <= w_first_win;
                r_buf_last[r_wr_ptr] <= w_last_win;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_buf_data[r_rd_ptr];
    assign m_axis_tuser  = r_buf_user[r_rd_ptr];
    assign m_axis_tlast  = r_buf_last[r_rd_ptr];
    assign max_value     = r_max;
    assign min_value     = r_min;
    assign frame_err     = r_err;

endmodule
`default_nettype wire
